// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline control-bit indices and MEM-stage FSM encoding
//
// Purpose : constants and types shared by the pipeline stages.
// Contents: CTL_* bit positions inside the 6-bit control word carried EX->MEM,
//           mem_state_t encoding of the memory-stage access FSM.
package pipeline_pkg;

    localparam int CTL_REG_WRITE  = 5;
    localparam int CTL_MEM_TO_REG = 4;
    localparam int CTL_BRANCH     = 3;
    localparam int CTL_MEM_READ   = 2;
    localparam int CTL_MEM_WRITE  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with bubble insertion on stall
//
// Purpose : holds the values handed from the memory stage to writeback.
//           While stall is high the control field is cleared (bubble) and the
//           data fields keep their previous value, so a held instruction is
//           written back exactly once, on the cycle stall drops.
// Ports   : clock, reset (async active-low), stall,
//           alu_result_in/read_data_in/reg_write_addr_in/control_in -> *_out.
module mem_wb_reg (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] read_data_in,
    input  logic [4:0]  reg_write_addr_in,
    input  logic [1:0]  control_in,
    output logic [31:0] alu_result_out,
    output logic [31:0] read_data_out,
    output logic [4:0]  reg_write_addr_out,
    output logic [1:0]  control_out
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_result_out     <= 32'd0;
            read_data_out      <= 32'd0;
            reg_write_addr_out <= 5'd0;
            control_out        <= 2'b00;
        end else if (stall) begin
            control_out        <= 2'b00;
        end else begin
            alu_result_out     <= alu_result_in;
            read_data_out      <= read_data_in;
            reg_write_addr_out <= reg_write_addr_in;
            control_out        <= control_in;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-stage controller: dmem handshake, stall, branch resolve, MEM/WB
//
// Purpose : consumes EX/MEM outputs, runs one data-memory access per load/store
//           over a valid/ready request and valid-only response channel, stalls
//           EX/MEM while the access is in flight, and loads the MEM/WB register.
// Ports   : clock, reset (async active-low)
//           EX/MEM in : pc_branch_M, zero_flag_M, ALU_result_M, reg_read_data2_M,
//                       reg_write_addr_M, control_M
//           hazard/fetch out : stall_M, pcsrc_M, pc_branch_out
//           dmem : dmem_req_valid/ready, dmem_we, dmem_addr, dmem_wdata,
//                  dmem_rsp_valid, dmem_rsp_rdata
//           MEM/WB out : read_data_W, ALU_result_W, reg_write_addr_W, control_W
//           align_err : one-cycle pulse when a misaligned access is dropped
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int CHECK_ALIGN = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       pc_branch_M,
    input  logic              zero_flag_M,
    input  logic [31:0]       ALU_result_M,
    input  logic [31:0]       reg_read_data2_M,
    input  logic [4:0]        reg_write_addr_M,
    input  logic [5:0]        control_M,
    output logic              stall_M,
    output logic              pcsrc_M,
    output logic [31:0]       pc_branch_out,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [31:0]       dmem_rsp_rdata,
    output logic [31:0]       read_data_W,
    output logic [31:0]       ALU_result_W,
    output logic [4:0]        reg_write_addr_W,
    output logic [1:0]        control_W,
    output logic              align_err
);

    mem_state_t  state;
    logic [31:0] rdata_q;

    logic mem_read;
    logic mem_write;
    logic mem_op;
    logic addr_misaligned;
    logic misalign_drop;
    logic unused_bits;

    assign mem_read  = control_M[CTL_MEM_READ];
    assign mem_write = control_M[CTL_MEM_WRITE];
    assign mem_op    = mem_read | mem_write;

    assign addr_misaligned = (CHECK_ALIGN != 0) && (ALU_result_M[1:0] != 2'b00);
    assign misalign_drop   = (state == ST_IDLE) && mem_op && addr_misaligned;

    // Gated by reset so EX/MEM is released the instant reset asserts, even
    // though the held inputs may still describe a memory op.
    assign stall_M = reset &&
                     (((state == ST_IDLE) && mem_op && !addr_misaligned) ||
                      (state == ST_REQ) || (state == ST_WAIT));

    assign pcsrc_M       = control_M[CTL_BRANCH] & zero_flag_M;
    assign pc_branch_out = pc_branch_M;

    // Request fields come straight from EX/MEM; the stall keeps them stable
    // for the whole REQ phase.
    assign dmem_req_valid = (state == ST_REQ);
    assign dmem_we        = mem_write;
    assign dmem_addr      = ALU_result_M[ADDR_W-1:0];
    assign dmem_wdata     = reg_read_data2_M;

    assign unused_bits = ^{control_M[0], ALU_result_M};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rdata_q   <= 32'd0;
            align_err <= 1'b0;
        end else begin
            align_err <= misalign_drop;
            case (state)
                ST_IDLE: begin
                    if (mem_op && !addr_misaligned) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmem_req_ready) begin
                        // A write needs no response; read+write counts as write.
                        state <= mem_write ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rsp_valid) begin
                        rdata_q <= dmem_rsp_rdata;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    logic [1:0]  wb_control;
    logic [31:0] wb_read_data;

    assign wb_control   = {control_M[CTL_REG_WRITE] & ~misalign_drop,
                           control_M[CTL_MEM_TO_REG]};
    assign wb_read_data = (state == ST_DONE) ? rdata_q : 32'd0;

    mem_wb_reg u_mem_wb_reg (
        .clock              (clock),
        .reset              (reset),
        .stall              (stall_M),
        .alu_result_in      (ALU_result_M),
        .read_data_in       (wb_read_data),
        .reg_write_addr_in  (reg_write_addr_M),
        .control_in         (wb_control),
        .alu_result_out     (ALU_result_W),
        .read_data_out      (read_data_W),
        .reg_write_addr_out (reg_write_addr_W),
        .control_out        (control_W)
    );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

    logic        clock;
    logic        reset;
    logic [31:0] pc_branch_M;
    logic        zero_flag_M;
    logic [31:0] ALU_result_M;
    logic [31:0] reg_read_data2_M;
    logic [4:0]  reg_write_addr_M;
    logic [5:0]  control_M;
    logic        stall_M;
    logic        pcsrc_M;
    logic [31:0] pc_branch_out;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic [31:0] read_data_W;
    logic [31:0] ALU_result_W;
    logic [4:0]  reg_write_addr_W;
    logic [1:0]  control_W;
    logic        align_err;

    mem_stage #(.ADDR_W(32), .CHECK_ALIGN(1)) dut (
        .clock            (clock),
        .reset            (reset),
        .pc_branch_M      (pc_branch_M),
        .zero_flag_M      (zero_flag_M),
        .ALU_result_M     (ALU_result_M),
        .reg_read_data2_M (reg_read_data2_M),
        .reg_write_addr_M (reg_write_addr_M),
        .control_M        (control_M),
        .stall_M          (stall_M),
        .pcsrc_M          (pcsrc_M),
        .pc_branch_out    (pc_branch_out),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_rsp_valid   (dmem_rsp_valid),
        .dmem_rsp_rdata   (dmem_rsp_rdata),
        .read_data_W      (read_data_W),
        .ALU_result_W     (ALU_result_W),
        .reg_write_addr_W (reg_write_addr_W),
        .control_W        (control_W),
        .align_err        (align_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [1:0]  ctl;
        logic [31:0] rdata;
    } wb_exp_t;

    wb_exp_t sb_q[$];

    typedef struct {
        logic [5:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pcb;
        logic        zf;
        logic        exp_pcsrc;
        logic        exp_align;
        logic [1:0]  exp_ctl;
    } vec_t;

    vec_t vecs[8];

    logic [31:0] last_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_pop_check();
        wb_exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: got an unexpected MEM/WB capture, expected none");
        end else begin
            e = sb_q.pop_front();
            chk("ALU_result_W", ALU_result_W, e.alu);
            chk("reg_write_addr_W", {27'd0, reg_write_addr_W}, {27'd0, e.rd});
            chk("control_W", {30'd0, control_W}, {30'd0, e.ctl});
            chk("read_data_W", read_data_W, e.rdata);
        end
    endtask

    // One clock: a capture happens on edges where stall_M was low, otherwise
    // the MEM/WB register must hold a bubble.
    task automatic step();
        logic s;
        s = stall_M;
        @(posedge clock);
        #1;
        if (!s) sb_pop_check();
        else    chk("bubble_control_W", {30'd0, control_W}, 32'd0);
        @(negedge clock);
    endtask

    task automatic issue(input logic [5:0] ctrl, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] pcb, input logic zf,
                         input logic [1:0] exp_ctl, input logic [31:0] exp_rdata, input bit push);
        wb_exp_t e;
        control_M        = ctrl;
        ALU_result_M     = alu;
        reg_read_data2_M = wd;
        reg_write_addr_M = rd;
        pc_branch_M      = pcb;
        zero_flag_M      = zf;
        if (push) begin
            e.alu = alu; e.rd = rd; e.ctl = exp_ctl; e.rdata = exp_rdata;
            sb_q.push_back(e);
        end
    endtask

    // Runs the currently issued memory op to completion. ready_at: cycle index
    // (0 = first IDLE cycle) from which dmem_req_ready is high. rsp_delay:
    // extra cycles after the cycle following the handshake before the response.
    task automatic run_mem(input string name, input int ready_at, input int rsp_delay,
                           input logic [31:0] rdata, input bit is_write, input int exp_stall);
        int cyc;
        int stalls;
        int hs;
        int hs_cyc;
        bit done;
        cyc = 0; stalls = 0; hs = 0; hs_cyc = -1; done = 0;
        while (!done && cyc < 40) begin
            dmem_req_ready = (cyc >= ready_at);
            dmem_rsp_valid = !is_write && (hs_cyc >= 0) && (cyc == hs_cyc + 1 + rsp_delay);
            dmem_rsp_rdata = dmem_rsp_valid ? rdata : (32'hBAD0_0000 | cyc);
            if (dmem_rsp_valid) last_rdata = rdata;
            #1;
            if (stall_M) stalls++;
            if (dmem_req_valid) begin
                chk({name, "_addr"}, dmem_addr, ALU_result_M);
                chk({name, "_we"}, {31'd0, dmem_we}, {31'd0, is_write});
                chk({name, "_wdata"}, dmem_wdata, reg_read_data2_M);
                if (dmem_req_ready) begin
                    hs++;
                    hs_cyc = cyc;
                end
            end
            if (!stall_M) done = 1;
            step();
            cyc++;
        end
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: stall_M still high after %0d cycles, expected release", name, cyc);
        end
        chk({name, "_stall_cycles"}, stalls, exp_stall);
        chk({name, "_handshakes"}, hs, 1);
    endtask

    initial begin
        reset            = 1'b0;
        dmem_req_ready   = 1'b0;
        dmem_rsp_valid   = 1'b0;
        dmem_rsp_rdata   = 32'd0;
        last_rdata       = 32'd0;
        issue(6'b000000, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 2'b00, 32'd0, 0);

        //                ctrl       alu           wd            rd     pcb           zf  pcs aln ctl
        vecs[0] = '{6'b100000, 32'h0000_1234, 32'h0,        5'd3,  32'h0,        1'b0, 1'b0, 1'b0, 2'b10};
        vecs[1] = '{6'b001000, 32'h0000_0000, 32'h0,        5'd0,  32'h0000_0100, 1'b1, 1'b1, 1'b0, 2'b00};
        vecs[2] = '{6'b001000, 32'h0000_0001, 32'h0,        5'd0,  32'h0000_0100, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[3] = '{6'b110100, 32'h0000_0042, 32'h0,        5'd9,  32'h0,        1'b0, 1'b0, 1'b1, 2'b01};
        vecs[4] = '{6'b100000, 32'h0000_0043, 32'h0,        5'd10, 32'h0,        1'b1, 1'b0, 1'b0, 2'b10};
        vecs[5] = '{6'b000010, 32'h0000_0081, 32'h1111_2222, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 2'b00};
        vecs[6] = '{6'b100010, 32'h0000_0002, 32'h3333_4444, 5'd11, 32'h0,       1'b0, 1'b0, 1'b1, 2'b00};
        vecs[7] = '{6'b011000, 32'hFFFF_FFFC, 32'h0,        5'd31, 32'h0000_0200, 1'b1, 1'b1, 1'b0, 2'b01};

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_stall_M", {31'd0, stall_M}, 32'd0);
        chk("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        chk("rst_read_data_W", read_data_W, 32'd0);
        chk("rst_ALU_result_W", ALU_result_W, 32'd0);
        chk("rst_control_W", {30'd0, control_W}, 32'd0);
        chk("rst_align_err", {31'd0, align_err}, 32'd0);
        reset = 1'b1;

        // Single-cycle ops: passthrough, branches, misaligned drops
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].ctrl, vecs[i].alu, vecs[i].wd, vecs[i].rd, vecs[i].pcb, vecs[i].zf,
                  vecs[i].exp_ctl, 32'd0, 1);
            #1;
            chk("vec_stall_M", {31'd0, stall_M}, 32'd0);
            chk("vec_pcsrc_M", {31'd0, pcsrc_M}, {31'd0, vecs[i].exp_pcsrc});
            chk("vec_pc_branch_out", pc_branch_out, vecs[i].pcb);
            chk("vec_req_valid", {31'd0, dmem_req_valid}, 32'd0);
            step();
            chk("vec_align_err", {31'd0, align_err}, {31'd0, vecs[i].exp_align});
        end

        // Load, immediate ready, response the next cycle
        issue(6'b110100, 32'h0000_0040, 32'h0, 5'd5, 32'h0, 1'b0, 2'b11, 32'hDEAD_BEEF, 1);
        run_mem("load1", 0, 0, 32'hDEAD_BEEF, 1'b0, 3);

        // Store, ready held off until cycle 3; read_data_W carries the old rdata_q
        issue(6'b000010, 32'h0000_0080, 32'hA5A5_A5A5, 5'd6, 32'h0, 1'b0, 2'b00, last_rdata, 1);
        run_mem("store1", 3, 0, 32'h0, 1'b1, 4);

        // Back-to-back: slow load, then read+write op that must act as a write
        issue(6'b110100, 32'h0000_0044, 32'h0, 5'd7, 32'h0, 1'b0, 2'b11, 32'h1357_9BDF, 1);
        run_mem("load2", 2, 1, 32'h1357_9BDF, 1'b0, 5);
        issue(6'b100110, 32'h0000_0048, 32'h0F0F_0F0F, 5'd8, 32'h0, 1'b0, 2'b10, last_rdata, 1);
        run_mem("rw_store", 0, 0, 32'h0, 1'b1, 2);

        // Reset while waiting for a load response
        issue(6'b110100, 32'h0000_0060, 32'h0, 5'd4, 32'h0, 1'b0, 2'b11, 32'h0, 0);
        dmem_req_ready = 1'b1;
        #1;
        chk("rw_idle_stall", {31'd0, stall_M}, 32'd1);
        step();
        #1;
        chk("rw_req_valid", {31'd0, dmem_req_valid}, 32'd1);
        step();
        dmem_req_ready = 1'b0;
        #1;
        chk("rw_wait_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        chk("rw_wait_stall", {31'd0, stall_M}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        chk("rst_mid_stall_M", {31'd0, stall_M}, 32'd0);
        chk("rst_mid_ALU_result_W", ALU_result_W, 32'd0);
        chk("rst_mid_reg_write_addr_W", {27'd0, reg_write_addr_W}, 32'd0);
        chk("rst_mid_control_W", {30'd0, control_W}, 32'd0);
        chk("rst_mid_read_data_W", read_data_W, 32'd0);
        last_rdata = 32'd0;
        issue(6'b000000, 32'h0000_0010, 32'h0, 5'd1, 32'h0, 1'b0, 2'b00, 32'd0, 1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Stray response in IDLE must not reach rdata_q or read_data_W
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h5555_5555;
        #1;
        chk("stray_stall_M", {31'd0, stall_M}, 32'd0);
        step();
        dmem_rsp_valid = 1'b0;
        issue(6'b000010, 32'h0000_0084, 32'hCAFE_0001, 5'd2, 32'h0, 1'b0, 2'b00, last_rdata, 1);
        run_mem("store2", 0, 0, 32'h0, 1'b1, 2);

        // Load after reset works normally
        issue(6'b110100, 32'h0000_0088, 32'h0, 5'd12, 32'h0, 1'b0, 2'b11, 32'h0BAD_F00D, 1);
        run_mem("load3", 0, 0, 32'h0BAD_F00D, 1'b0, 3);

        chk("sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
